// File: rtl/ps2_keyboard_rx_if.sv
// Consumer-facing bundle of the PS/2 keyboard receiver: raw PS/2 lines in,
// queued key events and error status out.
interface ps2_keyboard_rx_if;
    logic        PS2C;
    logic        PS2D;
    logic        InteAccept;
    logic [15:0] scanCode;
    logic        KeyBoardInte;
    logic        overflow;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output PS2C, PS2D, InteAccept,
        input  scanCode, KeyBoardInte, overflow, frame_err, err_count
    );

    modport slave (
        input  PS2C, PS2D, InteAccept,
        output scanCode, KeyBoardInte, overflow, frame_err, err_count
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, deserialise
// 11-bit frames, assemble make/break/extended events and queue them.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for a PS2C falling edge with data low (start bit)
//  SHIFT | capturing 8 data, parity and stop bits; watchdog armed
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit RAW_MODE       = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    ps2_keyboard_rx_if.slave bus
);
    localparam int FCW   = $clog2(FILTER_LEN);
    localparam int WDW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FCW-1:0] F_LOAD  = FCW'(FILTER_LEN - 1);
    localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    // index 0 = PS2C, index 1 = PS2D
    logic [1:0]     sync1, sync2, filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_filt_q;
    logic           fall;

    rx_state_t      state, state_nxt;
    logic           start, capture, stop_edge, timeout;
    logic [3:0]     bit_cnt;
    logic [WDW-1:0] wd_cnt;
    logic [8:0]     shreg;
    logic [9:0]     frame_bits;
    logic           frame_ok, bad;

    logic           byte_vld;
    logic [7:0]     byte_q;
    logic           ext, brk;
    logic           err_pulse;
    logic [7:0]     err_cnt;

    logic           push;
    logic [15:0]    push_data;
    logic [15:0]    mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_nxt;
    logic           full, pop, wr_en;
    logic           kbi_q, ovf_q;
    logic [15:0]    scan_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            clk_filt_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= F_LOAD;
        end else begin
            sync1      <= {bus.PS2D, bus.PS2C};
            sync2      <= sync1;
            clk_filt_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= F_LOAD;
                end else if (fcnt[i] == '0) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= F_LOAD;
                end else begin
                    fcnt[i] <= fcnt[i] - 1'b1;
                end
            end
        end
    end

    assign fall = clk_filt_q & ~filt[0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        stop_edge = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !filt[1]) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    capture = 1'b1;
                    if (bit_cnt == 4'd9) begin
                        stop_edge = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wd_cnt == '0) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // frame_bits: [7:0] data, [8] parity, [9] stop
    assign frame_bits = {filt[1], shreg};
    assign frame_ok   = frame_bits[9] & (^frame_bits[8:0]);
    assign bad        = (stop_edge & ~frame_ok) | timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            wd_cnt  <= '0;
            shreg   <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            wd_cnt  <= WD_LOAD;
        end else if (capture) begin
            shreg   <= {filt[1], shreg[8:1]};
            bit_cnt <= stop_edge ? 4'd0 : bit_cnt + 4'd1;
            wd_cnt  <= WD_LOAD;
        end else if (timeout) begin
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else if (state == SHIFT) begin
            wd_cnt  <= wd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            byte_vld  <= stop_edge & frame_ok;
            if (stop_edge) byte_q <= frame_bits[7:0];
            err_pulse <= bad;
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_vld && !RAW_MODE) begin
                if (byte_q == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        push      = 1'b0;
        push_data = {8'h00, byte_q};
        if (byte_vld) begin
            if (RAW_MODE) begin
                push = 1'b1;
            end else if (byte_q != 8'hE0 && byte_q != 8'hF0) begin
                push      = 1'b1;
                push_data = {brk, ext, 6'b0, byte_q};
            end
        end
    end

    assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop    = bus.InteAccept & kbi_q;
    assign wr_en  = push & (~full | pop);
    assign rd_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

    // Outputs see a push one cycle late but a pop immediately, so the head
    // shown with KeyBoardInte is never a stale, already-popped entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            kbi_q  <= 1'b0;
            scan_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            if (push && full && !pop) ovf_q <= 1'b1;
            kbi_q <= (wr_ptr != rd_nxt);
            if (wr_ptr != rd_nxt) scan_q <= mem[rd_nxt[FIFO_AW-1:0]];
        end
    end

    assign bus.scanCode     = scan_q;
    assign bus.KeyBoardInte = kbi_q;
    assign bus.overflow     = ovf_q;
    assign bus.frame_err    = err_pulse;
    assign bus.err_count    = err_cnt;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench: dut_a uses default parameters (event assembly), dut_b is a
// raw-mode, 4-deep, short-timeout instance; each has its own PS/2 lines.
module tb_ps2_keyboard_rx;
    localparam int HALF = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [1:0] ps2c, ps2d;
    logic       acc_a, acc_b;
    int n_assert = 0;
    int n_fail   = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int p0;

    ps2_keyboard_rx_if bus_a ();
    ps2_keyboard_rx_if bus_b ();

    assign bus_a.PS2C       = ps2c[0];
    assign bus_a.PS2D       = ps2d[0];
    assign bus_a.InteAccept = acc_a;
    assign bus_b.PS2C       = ps2c[1];
    assign bus_b.PS2D       = ps2d[1];
    assign bus_b.InteAccept = acc_b;

    ps2_keyboard_rx #(.FILTER_LEN(8), .FIFO_AW(4), .TIMEOUT_CYCLES(50000), .RAW_MODE(1'b0))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));

    ps2_keyboard_rx #(.FILTER_LEN(8), .FIFO_AW(2), .TIMEOUT_CYCLES(300), .RAW_MODE(1'b1))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));

    always @(negedge clk) begin
        if (bus_a.frame_err) pulses_a++;
        if (bus_b.frame_err) pulses_b++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input int sel, input logic [10:0] fr, input int nb);
        for (int i = 0; i < nb; i++) begin
            ps2d[sel] = fr[i];
            tick(HALF);
            ps2c[sel] = 1'b0;
            tick(HALF);
            ps2c[sel] = 1'b1;
        end
        tick(HALF);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        send_bits(sel, mk_frame(b, 1'b0), 11);
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) acc_a = 1'b1; else acc_b = 1'b1;
        @(negedge clk);
        acc_a = 1'b0;
        acc_b = 1'b0;
    endtask

    initial begin
        ps2c = 2'b11; ps2d = 2'b11; acc_a = 1'b0; acc_b = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        tick(3);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(2);

        check("rst_kbi",    {15'b0, bus_a.KeyBoardInte}, 16'h0000);
        check("rst_scan",   bus_a.scanCode, 16'h0000);
        check("rst_ovf",    {15'b0, bus_a.overflow}, 16'h0000);
        check("rst_ferr",   {15'b0, bus_a.frame_err}, 16'h0000);
        check("rst_errcnt", {8'b0, bus_a.err_count}, 16'h0000);

        // 0x1C with exact latency: 2 sync flops + 8 filter samples put the
        // filtered edge at raw+10; stop capture at +11, push +12, visible +13.
        send_bits(0, mk_frame(8'h1C, 1'b0), 10);
        ps2d[0] = 1'b1;
        tick(HALF);
        ps2c[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("lat_early_kbi", {15'b0, bus_a.KeyBoardInte}, 16'h0000);
        @(posedge clk);
        #1 check("lat_kbi",  {15'b0, bus_a.KeyBoardInte}, 16'h0001);
        check("lat_scan", bus_a.scanCode, 16'h001C);
        tick(HALF);
        ps2c[0] = 1'b1;
        tick(HALF);
        pop(0);
        check("pop_kbi",  {15'b0, bus_a.KeyBoardInte}, 16'h0000);
        check("hold_scan", bus_a.scanCode, 16'h001C);
        pop(0);
        check("empty_pop_kbi", {15'b0, bus_a.KeyBoardInte}, 16'h0000);

        send_byte(0, 8'hE0);
        send_byte(0, 8'hF0);
        send_byte(0, 8'h74);
        check("ext_brk_kbi",  {15'b0, bus_a.KeyBoardInte}, 16'h0001);
        check("ext_brk_scan", bus_a.scanCode, 16'hC074);
        pop(0);
        check("ext_brk_single", {15'b0, bus_a.KeyBoardInte}, 16'h0000);

        // parity error after E0 must also drop the pending extended flag
        send_byte(0, 8'hE0);
        p0 = pulses_a;
        send_bits(0, mk_frame(8'h1C, 1'b1), 11);
        check("par_pulses", 16'(pulses_a - p0), 16'h0001);
        check("par_errcnt", {8'b0, bus_a.err_count}, 16'h0001);
        check("par_kbi",    {15'b0, bus_a.KeyBoardInte}, 16'h0000);
        send_byte(0, 8'h1C);
        check("after_par_kbi",  {15'b0, bus_a.KeyBoardInte}, 16'h0001);
        check("after_par_scan", bus_a.scanCode, 16'h001C);

        // reset mid-frame with one event still queued
        send_bits(0, mk_frame(8'h55, 1'b0), 6);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check("mid_rst_kbi",    {15'b0, bus_a.KeyBoardInte}, 16'h0000);
        check("mid_rst_scan",   bus_a.scanCode, 16'h0000);
        check("mid_rst_errcnt", {8'b0, bus_a.err_count}, 16'h0000);
        check("mid_rst_ferr",   {15'b0, bus_a.frame_err}, 16'h0000);
        check("mid_rst_ovf",    {15'b0, bus_a.overflow}, 16'h0000);
        tick(HALF);
        send_byte(0, 8'h1C);
        check("post_rst_kbi",  {15'b0, bus_a.KeyBoardInte}, 16'h0001);
        check("post_rst_scan", bus_a.scanCode, 16'h001C);

        send_byte(1, 8'hE0);
        send_byte(1, 8'hF0);
        send_byte(1, 8'h74);
        check("raw_0", bus_b.scanCode, 16'h00E0);
        pop(1);
        check("raw_1", bus_b.scanCode, 16'h00F0);
        check("raw_1_kbi", {15'b0, bus_b.KeyBoardInte}, 16'h0001);
        pop(1);
        check("raw_2", bus_b.scanCode, 16'h0074);
        pop(1);
        check("raw_empty", {15'b0, bus_b.KeyBoardInte}, 16'h0000);

        for (int i = 1; i <= 5; i++) send_byte(1, 8'(i));
        check("ovf_set", {15'b0, bus_b.overflow}, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_head", bus_b.scanCode, 16'(i));
            check("ovf_kbi",  {15'b0, bus_b.KeyBoardInte}, 16'h0001);
            pop(1);
        end
        check("ovf_drained", {15'b0, bus_b.KeyBoardInte}, 16'h0000);
        check("ovf_sticky",  {15'b0, bus_b.overflow}, 16'h0001);

        p0 = pulses_b;
        send_bits(1, mk_frame(8'h29, 1'b0), 5);
        tick(400);
        check("to_pulses", 16'(pulses_b - p0), 16'h0001);
        check("to_errcnt", {8'b0, bus_b.err_count}, 16'h0001);
        check("to_kbi",    {15'b0, bus_b.KeyBoardInte}, 16'h0000);
        send_byte(1, 8'h29);
        check("after_to_kbi",  {15'b0, bus_b.KeyBoardInte}, 16'h0001);
        check("after_to_scan", bus_b.scanCode, 16'h0029);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal samples needed to change a filtered PS/2 line (range 2..32).
REQ-002 Parameter FIFO_AW, default 4: event FIFO depth is 2**FIFO_AW entries (range 1..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between PS2C falling edges inside a frame.
REQ-004 Parameter RAW_MODE, default 0: 1 queues every valid byte as-is; 0 assembles make/break/extended events.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 PS2C  input  1  raw PS/2 clock, asynchronous.
REQ-008 PS2D  input  1  raw PS/2 data, asynchronous.
REQ-009 InteAccept  input  1  consumer acknowledge; pops one event.
REQ-010 scanCode  output  16  head event: [15] break, [14] extended, [13:8] zero, [7:0] code.
REQ-011 KeyBoardInte  output  1  high while FIFO non-empty.
REQ-012 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-013 frame_err  output  1  one-cycle pulse on a start, parity, stop or timeout error.
REQ-014 err_count  output  8  saturating count of frame errors.

Function
REQ-015 PS2C and PS2D SHALL each pass a 2-flop synchroniser, then a filter that changes only after FILTER_LEN identical samples; filtered lines idle at 1.
REQ-016 A filtered-PS2C 1->0 transition SHALL be detected in a single cycle and sample filtered PS2D on that same cycle.
REQ-017 Receiver states SHALL be IDLE and SHIFT. IDLE->SHIFT on a falling edge with data 0 (start). A falling edge in IDLE with data 1 SHALL be ignored.
REQ-018 SHIFT SHALL capture 10 further bits, LSB first: 8 data, parity, stop. It SHALL return to IDLE on the edge that captures the stop bit.
REQ-019 The frame SHALL be valid iff data plus parity hold an odd number of ones and stop = 1. Otherwise frame_err pulses, err_count increments (saturating at 255), and no byte is produced.
REQ-020 In SHIFT, a watchdog SHALL restart on each falling edge. Reaching TIMEOUT_CYCLES SHALL force IDLE, discard the partial frame and count as a frame error.
REQ-021 RAW_MODE=1: each valid byte B SHALL be pushed as {8'h00,B}.
REQ-022 RAW_MODE=0: byte E0 sets the ext flag and F0 sets the brk flag, neither pushed. Any other byte B SHALL push {brk,ext,6'b0,B} and clear both flags.
REQ-023 RAW_MODE=0: any frame error SHALL clear ext and brk.
REQ-024 A push SHALL occur exactly 1 cycle after the stop-bit edge. KeyBoardInte and scanCode SHALL be valid the cycle after the push (2-cycle latency from the stop edge).
REQ-025 scanCode SHALL always equal the FIFO head while KeyBoardInte=1. When empty it SHALL hold its last value.
REQ-026 InteAccept with KeyBoardInte=1 SHALL pop one entry. The next entry, if any, SHALL appear on scanCode the following cycle and KeyBoardInte SHALL stay high. InteAccept while empty SHALL be ignored.
REQ-027 A push into a full FIFO with no simultaneous pop SHALL be dropped and set overflow. A simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-028 Read and write pointers SHALL be FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1). Full and empty SHALL be decoded from the MSB and equality.
REQ-029 overflow SHALL be cleared only by reset.

Reset
REQ-030 With rst_n=0 at a clk edge, the following SHALL be reset:
- receiver to IDLE, bit count 0, watchdog 0;
- ext and brk flags 0; FIFO pointers 0;
- filtered lines and synchronisers 1;
- KeyBoardInte 0, scanCode 16'h0000, overflow 0, frame_err 0, err_count 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame. The first complete frame after release SHALL be received correctly.

Verification
REQ-032 Defaults, frame 0x1C with parity 0 and stop 1 -> scanCode=16'h001C and KeyBoardInte=1, 2 cycles after the stop edge. InteAccept pulse -> KeyBoardInte=0.
REQ-033 RAW_MODE=0, frames E0,F0,74 -> single event 16'hC074. RAW_MODE=1, same frames -> 16'h00E0, 16'h00F0, 16'h0074 in order.
REQ-034 Frame 0x1C with parity 1 -> frame_err pulses once, err_count=1, FIFO unchanged. The next good frame 0x1C is queued.
REQ-035 FIFO_AW=2, 5 codes 0x01..0x05 sent with no InteAccept -> overflow=1. Four pops return 0x0001..0x0004, then KeyBoardInte=0.
REQ-036 Start bit plus 4 bits, then stall beyond TIMEOUT_CYCLES -> frame_err pulses and the receiver returns to IDLE. The next full frame 0x29 yields 16'h0029.
REQ-037 rst_n=0 for 1 cycle after 6 bits of a frame -> all outputs at reset values. The subsequent frame 0x1C yields 16'h001C.
